// File: rtl/score_cmd_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface   : score_cmd_gen_if                                   |
// | Description : Raw push-button inputs, single-cycle counter       |
// |               commands and debounced button levels for           |
// |               score_cmd_gen.                                     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface score_cmd_gen_if;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_clr;
  logic       inc;
  logic       dec;
  logic       clr;
  logic [2:0] btn_lvl;

  // Button panel / stimulus side
  modport master (
    output btn_up, btn_dn, btn_clr,
    input  inc, dec, clr, btn_lvl
  );

  // Command generator side
  modport slave (
    input  btn_up, btn_dn, btn_clr,
    output inc, dec, clr, btn_lvl
  );
endinterface
`default_nettype wire

// File: rtl/score_cmd_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : score_cmd_gen                                      |
// | Description : Synchronizes, debounces and arbitrates three raw   |
// |               push-buttons (up, down, clear) into one-cycle      |
// |               inc/dec/clr commands for the 2-digit BCD counter.  |
// |               Optional auto-repeat while a single direction      |
// |               button is held: define AUTO_REPEAT_EN.             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module score_cmd_gen #(
  parameter int DB_CYCLES    = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  wire logic         clk,
  input  wire logic         reset,
  score_cmd_gen_if.slave    bus
);

  localparam int CW = $clog2(DB_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UP_HELD   = 3'd1,
    ST_DN_HELD   = 3'd2,
    ST_CLR_HELD  = 3'd3,
    ST_BOTH_HELD = 3'd4
  } state_t;

  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_stable;

  assign w_raw = {bus.btn_clr, bus.btn_dn, bus.btn_up};

  // Two-flop synchronizer for each raw button
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_db
      logic [CW-1:0] r_cnt;
      logic          r_stb;

      // Accept a level change only after DB_CYCLES consecutive differing samples
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
          r_stb <= 1'b0;
        end else if (r_sync2[gi] == r_stb) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
          r_stb <= r_sync2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_stable[gi] = r_stb;
    end
  endgenerate

  logic w_u;
  logic w_d;
  logic w_c;
  logic w_none;

  assign w_u    = w_stable[0];
  assign w_d    = w_stable[1];
  assign w_c    = w_stable[2];
  assign w_none = ~|w_stable;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_inc, r_dec, r_clr;
  logic   w_inc_nxt, w_dec_nxt, w_clr_nxt;
  logic   w_rep_fire;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  logic [RW-1:0] r_rep;
  logic          r_rep_first;
  logic [RW-1:0] w_rep_target;
  logic          w_only_owner;

  // Repeat timing only runs while the owning button is the only one held;
  // the entry edge is seen from IDLE, so counting starts fresh there.
  assign w_only_owner = ((r_state == ST_UP_HELD) && w_u && !w_d && !w_c) ||
                        ((r_state == ST_DN_HELD) && w_d && !w_u && !w_c);
  assign w_rep_target = r_rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);
  assign w_rep_fire   = w_only_owner && (r_rep == w_rep_target);

  // Repeat counter: first interval REPEAT_DELAY, then REPEAT_RATE
  always_ff @(posedge clk) begin
    if (reset || !w_only_owner) begin
      r_rep       <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep       <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end
`else
  logic w_unused_repeat_cfg;

  assign w_rep_fire          = 1'b0;
  assign w_unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

  // Press-tracking state and registered command pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
      r_clr   <= w_clr_nxt;
    end
  end

  // Next state and pulse selection; clear always wins and at most one pulse is raised.
  // A held state is only entered with clr low, so clr seen high there is a fresh press.
  always_comb begin
    w_state_nxt = r_state;
    w_inc_nxt   = 1'b0;
    w_dec_nxt   = 1'b0;
    w_clr_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_c) begin
          w_state_nxt = ST_CLR_HELD;
          w_clr_nxt   = 1'b1;
        end else if (w_u && w_d) begin
          w_state_nxt = ST_BOTH_HELD;
        end else if (w_u) begin
          w_state_nxt = ST_UP_HELD;
          w_inc_nxt   = 1'b1;
        end else if (w_d) begin
          w_state_nxt = ST_DN_HELD;
          w_dec_nxt   = 1'b1;
        end
      end
      ST_UP_HELD, ST_DN_HELD, ST_BOTH_HELD: begin
        if (w_c) begin
          w_state_nxt = ST_CLR_HELD;
          w_clr_nxt   = 1'b1;
        end else if (w_none) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rep_fire) begin
          if (r_state == ST_UP_HELD) begin
            w_inc_nxt = 1'b1;
          end else begin
            w_dec_nxt = 1'b1;
          end
        end
      end
      ST_CLR_HELD: begin
        if (w_none) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.inc     = r_inc;
  assign bus.dec     = r_dec;
  assign bus.clr     = r_clr;
  assign bus.btn_lvl = w_stable;

endmodule
`default_nettype wire

// File: tb/tb_score_cmd_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_score_cmd_gen                                   |
// | Description : Self-checking bench for score_cmd_gen: table of    |
// |               press phases, timed corner sequences and random    |
// |               bouncing buttons against a behavioural model.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_score_cmd_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  score_cmd_gen_if u_if ();

  score_cmd_gen #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit [2:0]    m_s1, m_s2, m_stable;
  bit [DB-1:0] m_hist [3];
  bit          m_busy, m_clr_sess;
  int          m_owner;     // 0 none, 1 up, 2 down
  int          m_t, m_run_start;
  bit          m_inc, m_dec, m_clr;

  // Per-sequence bookkeeping
  int seq_edge;
  int q_inc[$];
  int q_dec[$];
  int q_clr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock edge of the reference behaviour
  task automatic model_edge(input bit r, input bit [2:0] raw);
    bit up, dn, cl, only;
    bit pi, pd, pc;
    int d;
    m_t++;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
      m_busy = 0; m_clr_sess = 0; m_owner = 0;
      m_inc = 0; m_dec = 0; m_clr = 0;
      return;
    end
    up = m_stable[0]; dn = m_stable[1]; cl = m_stable[2];
    pi = 0; pd = 0; pc = 0;
    if (!m_busy) begin
      if (cl) begin
        pc = 1; m_busy = 1; m_clr_sess = 1; m_owner = 0;
      end else if (up && dn) begin
        m_busy = 1; m_owner = 0;
      end else if (up) begin
        pi = 1; m_busy = 1; m_owner = 1; m_run_start = m_t;
      end else if (dn) begin
        pd = 1; m_busy = 1; m_owner = 2; m_run_start = m_t;
      end
    end else if (!m_clr_sess && cl) begin
      pc = 1; m_clr_sess = 1; m_owner = 0;
    end else if (!up && !dn && !cl) begin
      m_busy = 0; m_clr_sess = 0; m_owner = 0;
    end else begin
`ifdef AUTO_REPEAT_EN
      if (m_owner != 0 && !m_clr_sess) begin
        only = (m_owner == 1) ? (up && !dn && !cl) : (dn && !up && !cl);
        if (!only) begin
          m_run_start = m_t;
        end else begin
          d = m_t - m_run_start;
          if (d == RD || (d > RD && ((d - RD) % RR) == 0)) begin
            if (m_owner == 1) pi = 1; else pd = 1;
          end
        end
      end
`else
      only = 0;
      d    = 0;
`endif
    end
    // a level is accepted once the last DB synchronized samples all disagree with it
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
      if (m_hist[b] == {DB{~m_stable[b]}}) m_stable[b] = ~m_stable[b];
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_inc = pi; m_dec = pd; m_clr = pc;
  endtask

  // Drive inputs, take one edge, compare against the model and log pulses
  task automatic step(input bit r, input bit [2:0] b);
    reset      = r;
    u_if.btn_up  = b[0];
    u_if.btn_dn  = b[1];
    u_if.btn_clr = b[2];
    @(posedge clk);
    model_edge(r, b);
    #1;
    check("model", {26'd0, u_if.inc, u_if.dec, u_if.clr, u_if.btn_lvl},
                   {26'd0, m_inc, m_dec, m_clr, m_stable});
    if (u_if.inc) q_inc.push_back(seq_edge);
    if (u_if.dec) q_dec.push_back(seq_edge);
    if (u_if.clr) q_clr.push_back(seq_edge);
    seq_edge++;
  endtask

  task automatic seq_start();
    seq_edge = 0;
    q_inc.delete(); q_dec.delete(); q_clr.delete();
  endtask

  typedef struct {
    bit       rst;
    bit [2:0] btn;      // {clr, dn, up}
    int       ncyc;
    int       e_inc, e_dec, e_clr;
    bit [2:0] e_lvl;
  } phase_t;

  phase_t tbl[20];

  initial begin
    int rise, fall, L, rep_n;
    bit [2:0] base, b;
    int exp_rep[6];

    u_if.btn_up = 0; u_if.btn_dn = 0; u_if.btn_clr = 0;

    tbl[0]  = '{1, 3'b000,  3, 0, 0, 0, 3'b000};
    tbl[1]  = '{0, 3'b001, 12, 1, 0, 0, 3'b001};
    tbl[2]  = '{0, 3'b000, 12, 0, 0, 0, 3'b000};
    tbl[3]  = '{0, 3'b010, 12, 0, 1, 0, 3'b010};
    tbl[4]  = '{0, 3'b000, 12, 0, 0, 0, 3'b000};
    tbl[5]  = '{0, 3'b011, 12, 0, 0, 0, 3'b011};
    tbl[6]  = '{0, 3'b111, 12, 0, 0, 1, 3'b111};
    tbl[7]  = '{0, 3'b000, 12, 0, 0, 0, 3'b000};
    tbl[8]  = '{0, 3'b001, 12, 1, 0, 0, 3'b001};
    tbl[9]  = '{0, 3'b011, 12, 0, 0, 0, 3'b011};
    tbl[10] = '{0, 3'b001, 12, 0, 0, 0, 3'b001};
    tbl[11] = '{0, 3'b000, 12, 0, 0, 0, 3'b000};
    tbl[12] = '{0, 3'b100, 12, 0, 0, 1, 3'b100};
    tbl[13] = '{0, 3'b101, 12, 0, 0, 0, 3'b101};
    tbl[14] = '{0, 3'b001, 12, 0, 0, 0, 3'b001};
    tbl[15] = '{0, 3'b000, 12, 0, 0, 0, 3'b000};
    tbl[16] = '{0, 3'b001, 12, 1, 0, 0, 3'b001};
    tbl[17] = '{1, 3'b001,  2, 0, 0, 0, 3'b000};
    tbl[18] = '{0, 3'b001, 12, 1, 0, 0, 3'b001};
    tbl[19] = '{0, 3'b000, 12, 0, 0, 0, 3'b000};

    // Reset state
    step(1, 3'b000);
    step(1, 3'b000);
    check("reset_outputs", {26'd0, u_if.inc, u_if.dec, u_if.clr, u_if.btn_lvl}, 32'd0);

    // Press-phase table
    for (int i = 0; i < 20; i++) begin
      seq_start();
      for (int k = 0; k < tbl[i].ncyc; k++) step(tbl[i].rst, tbl[i].btn);
      check($sformatf("tbl%0d_inc", i), q_inc.size(), tbl[i].e_inc);
      check($sformatf("tbl%0d_dec", i), q_dec.size(), tbl[i].e_dec);
      check($sformatf("tbl%0d_clr", i), q_clr.size(), tbl[i].e_clr);
      check($sformatf("tbl%0d_lvl", i), {29'd0, u_if.btn_lvl}, {29'd0, tbl[i].e_lvl});
    end

    // Latency: up sampled high at edge 0, held 50 cycles
    step(1, 3'b000); step(1, 3'b000);
    seq_start();
    rise = -1; fall = -1;
    for (int k = 0; k < 70; k++) begin
      step(0, (k < 50) ? 3'b001 : 3'b000);
      if (u_if.btn_lvl[0] && rise < 0) rise = k;
      if (!u_if.btn_lvl[0] && rise >= 0 && fall < 0) fall = k;
    end
    check("lat_inc_edge", (q_inc.size() == 1) ? q_inc[0] : -1, 6);
    check("lat_dec_clr", q_dec.size() + q_clr.size(), 0);
    check("lat_lvl_rise", rise, 5);
    check("lat_lvl_fall", fall, 55);

    // Bounce: dn 3-high/1-low for 20 cycles, then steady from edge 20
    step(1, 3'b000); step(1, 3'b000);
    seq_start();
    for (int k = 0; k < 45; k++)
      step(0, (k >= 20 || (k % 4) != 3) ? 3'b010 : 3'b000);
    check("bounce_dec_edge", (q_dec.size() == 1) ? q_dec[0] : -1, 26);
    check("bounce_inc_clr", q_inc.size() + q_clr.size(), 0);
    for (int k = 0; k < 12; k++) step(0, 3'b000);

    // Reset for two cycles in the middle of an up hold
    for (int k = 0; k < 20; k++) step(0, 3'b001);
    seq_start();
    step(1, 3'b001);
    check("rst_hold_out0", {26'd0, u_if.inc, u_if.dec, u_if.clr, u_if.btn_lvl}, 32'd0);
    step(1, 3'b001);
    check("rst_hold_out1", {26'd0, u_if.inc, u_if.dec, u_if.clr, u_if.btn_lvl}, 32'd0);
    for (int k = 2; k < 22; k++) step(0, 3'b001);
    check("rst_hold_inc_edge", (q_inc.size() == 1) ? q_inc[0] : -1, 8);
    for (int k = 0; k < 12; k++) step(0, 3'b000);

    // Long hold: auto-repeat schedule, or a single pulse when repeat is absent
`ifdef AUTO_REPEAT_EN
    exp_rep = '{6, 26, 34, 42, 50, 58};
    rep_n = 6;
`else
    exp_rep = '{6, 0, 0, 0, 0, 0};
    rep_n = 1;
`endif
    step(1, 3'b000); step(1, 3'b000);
    seq_start();
    for (int k = 0; k < 90; k++) step(0, (k < 60) ? 3'b001 : 3'b000);
    check("hold_inc_count", q_inc.size(), rep_n);
    for (int i = 0; i < rep_n; i++)
      check($sformatf("hold_inc_edge%0d", i), (q_inc.size() > i) ? q_inc[i] : -1, exp_rep[i]);
    check("hold_dec_clr", q_dec.size() + q_clr.size(), 0);

    // Random bouncing buttons against the model
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(29, 0) == 0) begin
        for (int k = 0; k < int'($urandom_range(2, 1)); k++) step(1, 3'($urandom));
      end
      base = 3'($urandom);
      L = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 20)) : int'($urandom_range(15, 1));
      for (int k = 0; k < L; k++) begin
        b = base;
        if ($urandom_range(7, 0) == 0) b[$urandom_range(2, 0)] ^= 1'b1;
        step(0, b);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
